// File: rtl/normalizer_pkg.sv
// Shared types and constants for the normalizer front end.
package normalizer_pkg;

    typedef enum logic [1:0] {
        StFill   = 2'd0,
        StReport = 2'd1,
        StDrain  = 2'd2
    } state_e;

    localparam logic [15:0] MAG_SAT  = 16'h7FFF;
    localparam logic [15:0] MIN_INIT = 16'h7FFF;

    // Absolute value of a two's-complement sample; -32768 clips to the largest magnitude.
    function automatic logic [15:0] mag_of(input logic [15:0] raw);
        if (raw == 16'h8000) begin
            return MAG_SAT;
        end
        return raw[15] ? (~raw + 16'd1) : raw;
    endfunction

endpackage

// File: rtl/normalizer_pair_ram.sv
// Simple dual-port pair buffer: one write port, one synchronous read port (1-cycle latency).
module normalizer_pair_ram #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/normalizer_prep.sv
// Buffers one frame of raw signed pairs, reports max/min magnitude, then replays the
// frame as sign-magnitude pairs. Single-buffered: the next frame waits for the drain.
module normalizer_prep
    import normalizer_pkg::*;
#(
    parameter int unsigned PAIRS = 128,
    parameter int unsigned AW    = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [15:0] raw_data_1,
    input  logic [15:0] raw_data_2,
    input  logic        raw_valid,
    output logic        raw_rdy,
    output logic [15:0] max,
    output logic [15:0] min,
    output logic        norm_start,
    output logic        sspect_minus_1,
    output logic [15:0] sspect_data_1,
    output logic        sspect_minus_2,
    output logic [15:0] sspect_data_2,
    output logic        sspect_valid,
    input  logic        sspect_rdy,
    output logic        busy
);

    localparam logic [AW-1:0] LAST = AW'(PAIRS - 1);

    state_e        r_state, w_state_nxt;
    logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [AW-1:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [15:0]   r_acc_max, w_acc_max_nxt;
    logic [15:0]   r_acc_min, w_acc_min_nxt;
    logic [15:0]   r_max, w_max_nxt;
    logic [15:0]   r_min, w_min_nxt;
    logic          r_sspect_valid, w_sspect_valid_nxt;
    logic          r_raw_rdy;

    logic          w_raw_hs, w_out_hs, w_we;
    logic [15:0]   w_mag1, w_mag2, w_pair_max, w_pair_min, w_new_max, w_new_min;
    logic [31:0]   w_rdata;

    assign w_raw_hs = raw_valid & r_raw_rdy & (r_state == StFill);
    assign w_out_hs = r_sspect_valid & sspect_rdy;

    assign w_mag1     = mag_of(raw_data_1);
    assign w_mag2     = mag_of(raw_data_2);
    assign w_pair_max = (w_mag1 > w_mag2) ? w_mag1 : w_mag2;
    assign w_pair_min = (w_mag1 < w_mag2) ? w_mag1 : w_mag2;
    assign w_new_max  = (w_pair_max > r_acc_max) ? w_pair_max : r_acc_max;
    assign w_new_min  = (w_pair_min < r_acc_min) ? w_pair_min : r_acc_min;

    always_comb begin
        w_state_nxt        = r_state;
        w_wr_ptr_nxt       = r_wr_ptr;
        w_rd_ptr_nxt       = r_rd_ptr;
        w_acc_max_nxt      = r_acc_max;
        w_acc_min_nxt      = r_acc_min;
        w_max_nxt          = r_max;
        w_min_nxt          = r_min;
        w_sspect_valid_nxt = r_sspect_valid;
        w_we               = 1'b0;

        if (frame_start) begin
            w_state_nxt        = StFill;
            w_wr_ptr_nxt       = '0;
            w_rd_ptr_nxt       = '0;
            w_acc_max_nxt      = '0;
            w_acc_min_nxt      = MIN_INIT;
            w_sspect_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                StFill: begin
                    if (w_raw_hs) begin
                        w_we          = 1'b1;
                        w_wr_ptr_nxt  = r_wr_ptr + AW'(1);
                        w_acc_max_nxt = w_new_max;
                        w_acc_min_nxt = w_new_min;
                        if (r_wr_ptr == LAST) begin
                            // Load the report registers now so they appear with norm_start.
                            w_state_nxt = StReport;
                            w_max_nxt   = w_new_max;
                            w_min_nxt   = w_new_min;
                        end
                    end
                end
                StReport: begin
                    w_rd_ptr_nxt       = '0;
                    w_sspect_valid_nxt = 1'b1;
                    w_state_nxt        = StDrain;
                end
                StDrain: begin
                    if (w_out_hs) begin
                        if (r_rd_ptr == LAST) begin
                            w_sspect_valid_nxt = 1'b0;
                            w_rd_ptr_nxt       = '0;
                            w_acc_max_nxt      = '0;
                            w_acc_min_nxt      = MIN_INIT;
                            w_state_nxt        = StFill;
                        end else begin
                            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
                        end
                    end
                end
                default: w_state_nxt = StFill;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= StFill;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_acc_max      <= '0;
            r_acc_min      <= MIN_INIT;
            r_max          <= '0;
            r_min          <= '0;
            r_sspect_valid <= 1'b0;
            r_raw_rdy      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_acc_max      <= w_acc_max_nxt;
            r_acc_min      <= w_acc_min_nxt;
            r_max          <= w_max_nxt;
            r_min          <= w_min_nxt;
            r_sspect_valid <= w_sspect_valid_nxt;
            r_raw_rdy      <= (w_state_nxt == StFill);
        end
    end

    // Read address follows the next rd_ptr, so read data always holds the pair at rd_ptr.
    normalizer_pair_ram #(
        .DEPTH (PAIRS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata ({raw_data_1, raw_data_2}),
        .i_raddr (w_rd_ptr_nxt),
        .o_rdata (w_rdata)
    );

    assign raw_rdy        = r_raw_rdy;
    assign max            = r_max;
    assign min            = r_min;
    assign norm_start     = (r_state == StReport);
    assign busy           = (r_state != StFill);
    assign sspect_valid   = r_sspect_valid;
    assign sspect_minus_1 = r_sspect_valid & w_rdata[31];
    assign sspect_minus_2 = r_sspect_valid & w_rdata[15];
    assign sspect_data_1  = r_sspect_valid ? mag_of(w_rdata[31:16]) : 16'd0;
    assign sspect_data_2  = r_sspect_valid ? mag_of(w_rdata[15:0]) : 16'd0;

endmodule

// File: tb/tb_normalizer_prep.sv
// Directed, table-driven bench for normalizer_prep with a 4-pair frame.
module tb_normalizer_prep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] raw_data_1 = '0;
    logic [15:0] raw_data_2 = '0;
    logic        raw_valid = 1'b0;
    logic        raw_rdy;
    logic [15:0] max_v, min_v;
    logic        norm_start;
    logic        sspect_minus_1, sspect_minus_2;
    logic [15:0] sspect_data_1, sspect_data_2;
    logic        sspect_valid;
    logic        sspect_rdy = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] d1;
        logic [15:0] d2;
        logic        m1;
        logic [15:0] a1;
        logic        m2;
        logic [15:0] a2;
    } pair_t;

    pair_t       vec [20];
    logic [15:0] exp_max [5];
    logic [15:0] exp_min [5];

    normalizer_prep #(
        .PAIRS (4),
        .AW    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .raw_data_1     (raw_data_1),
        .raw_data_2     (raw_data_2),
        .raw_valid      (raw_valid),
        .raw_rdy        (raw_rdy),
        .max            (max_v),
        .min            (min_v),
        .norm_start     (norm_start),
        .sspect_minus_1 (sspect_minus_1),
        .sspect_data_1  (sspect_data_1),
        .sspect_minus_2 (sspect_minus_2),
        .sspect_data_2  (sspect_data_2),
        .sspect_valid   (sspect_valid),
        .sspect_rdy     (sspect_rdy),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input int d1, input int d2,
                           input int m1, input int a1, input int m2, input int a2);
        vec[i].d1 = 16'(d1);
        vec[i].d2 = 16'(d2);
        vec[i].m1 = 1'(m1);
        vec[i].a1 = 16'(a1);
        vec[i].m2 = 1'(m2);
        vec[i].a2 = 16'(a2);
    endtask

    // Fills one frame starting at vec[base]; returns on the norm_start cycle.
    task automatic send_frame(input int base, input int f);
        for (int i = 0; i < 4; i++) begin
            int w = 0;
            raw_data_1 = vec[base + i].d1;
            raw_data_2 = vec[base + i].d2;
            raw_valid  = 1'b1;
            while (!raw_rdy && w < 50) begin
                @(negedge clk);
                w++;
            end
            chk("fill_raw_rdy", raw_rdy, 1);
            @(negedge clk);
        end
        raw_valid = 1'b0;
        chk("report_norm_start", norm_start, 1);
        chk("report_max", max_v, exp_max[f]);
        chk("report_min", min_v, exp_min[f]);
        chk("report_busy", busy, 1);
        chk("report_raw_rdy", raw_rdy, 0);
        chk("report_valid", sspect_valid, 0);
    endtask

    // Consumes 'stop' pairs; patterned applies rdy = 1,0,0,1,...
    task automatic drain(input int base, input bit patterned, input int stop);
        int idx = 0;
        int cyc = 0;
        logic [3:0] pat = 4'b1001;
        while (idx < stop && cyc < 40) begin
            @(negedge clk);
            chk("drain_valid", sspect_valid, 1);
            if (sspect_valid) begin
                chk("drain_minus_1", sspect_minus_1, vec[base + idx].m1);
                chk("drain_data_1", sspect_data_1, vec[base + idx].a1);
                chk("drain_minus_2", sspect_minus_2, vec[base + idx].m2);
                chk("drain_data_2", sspect_data_2, vec[base + idx].a2);
            end
            chk("drain_raw_rdy", raw_rdy, 0);
            chk("drain_busy", busy, 1);
            sspect_rdy = patterned ? pat[cyc % 4] : 1'b1;
            if (sspect_valid && sspect_rdy) idx++;
            cyc++;
        end
        chk("drain_progress", 32'(idx), 32'(stop));
        @(negedge clk);
        sspect_rdy = 1'b0;
        if (stop == 4) begin
            chk("drain_end_valid", sspect_valid, 0);
            chk("drain_end_raw_rdy", raw_rdy, 1);
            chk("drain_end_busy", busy, 0);
            if (!patterned) chk("drain_cycles", 32'(cyc), 32'd4);
        end
    endtask

    initial begin
        // F0 basic
        set_vec(0, 5, -3, 0, 5, 1, 3);
        set_vec(1, -7, 2, 1, 7, 0, 2);
        set_vec(2, 0, 1, 0, 0, 0, 1);
        set_vec(3, 4, -6, 0, 4, 1, 6);
        exp_max[0] = 16'd7;     exp_min[0] = 16'd0;
        // F1 saturation
        set_vec(4, -32768, 32767, 1, 32767, 0, 32767);
        set_vec(5, 1, -1, 0, 1, 1, 1);
        set_vec(6, 2, -2, 0, 2, 1, 2);
        set_vec(7, 3, -3, 0, 3, 1, 3);
        exp_max[1] = 16'd32767; exp_min[1] = 16'd1;
        // F2 / F3 back-to-back equal magnitudes
        set_vec(8, 9, -9, 0, 9, 1, 9);
        set_vec(9, -9, 9, 1, 9, 0, 9);
        set_vec(10, 9, 9, 0, 9, 0, 9);
        set_vec(11, -9, -9, 1, 9, 1, 9);
        exp_max[2] = 16'd9;     exp_min[2] = 16'd9;
        set_vec(12, 2, -2, 0, 2, 1, 2);
        set_vec(13, -2, 2, 1, 2, 0, 2);
        set_vec(14, 2, 2, 0, 2, 0, 2);
        set_vec(15, -2, -2, 1, 2, 1, 2);
        exp_max[3] = 16'd2;     exp_min[3] = 16'd2;
        // F4 fresh frame after abort
        set_vec(16, 3, 4, 0, 3, 0, 4);
        set_vec(17, 5, 6, 0, 5, 0, 6);
        set_vec(18, 7, 8, 0, 7, 0, 8);
        set_vec(19, 10, -9, 0, 10, 1, 9);
        exp_max[4] = 16'd10;    exp_min[4] = 16'd3;

        #1 rst = 1'b0;
        #2;
        chk("rst_raw_rdy", raw_rdy, 0);
        chk("rst_max", max_v, 0);
        chk("rst_min", min_v, 0);
        chk("rst_norm_start", norm_start, 0);
        chk("rst_valid", sspect_valid, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_raw_rdy", raw_rdy, 1);

        send_frame(0, 0);
        drain(0, 1'b0, 4);

        send_frame(4, 1);
        drain(4, 1'b1, 4);

        // F3's first pair waits on the bus through F2's drain.
        send_frame(8, 2);
        raw_data_1 = vec[12].d1;
        raw_data_2 = vec[12].d2;
        raw_valid  = 1'b1;
        drain(8, 1'b1, 4);
        send_frame(12, 3);
        drain(12, 1'b0, 4);

        // Abort during fill; the pair offered with frame_start is discarded.
        raw_data_1 = 16'd100;
        raw_data_2 = 16'hFF9C;
        raw_valid  = 1'b1;
        @(negedge clk);
        raw_data_1 = 16'd0;
        raw_data_2 = 16'd0;
        @(negedge clk);
        frame_start = 1'b1;
        raw_data_1  = 16'd200;
        raw_data_2  = 16'd0;
        @(negedge clk);
        frame_start = 1'b0;
        raw_valid   = 1'b0;
        chk("abort_fill_raw_rdy", raw_rdy, 1);
        chk("abort_fill_norm_start", norm_start, 0);
        chk("abort_fill_max_held", max_v, 2);
        chk("abort_fill_min_held", min_v, 2);
        send_frame(16, 4);

        // Abort mid-drain.
        drain(16, 1'b0, 2);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("abort_drain_valid", sspect_valid, 0);
        chk("abort_drain_busy", busy, 0);
        chk("abort_drain_raw_rdy", raw_rdy, 1);
        chk("abort_drain_max", max_v, 10);
        chk("abort_drain_min", min_v, 3);

        // Asynchronous reset mid-drain.
        send_frame(0, 0);
        drain(0, 1'b0, 1);
        chk("pre_arst_valid", sspect_valid, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", sspect_valid, 0);
        chk("arst_data_1", sspect_data_1, 0);
        chk("arst_minus_2", sspect_minus_2, 0);
        chk("arst_max", max_v, 0);
        chk("arst_min", min_v, 0);
        chk("arst_busy", busy, 0);
        chk("arst_raw_rdy", raw_rdy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_release_raw_rdy", raw_rdy, 1);
        chk("arst_release_busy", busy, 0);
        send_frame(4, 1);
        drain(4, 1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/normalizer_prep.md
Name: normalizer_prep

Overview:
- Upstream stage of normalizer_sqrt.
- Buffers one frame of raw signed spectrum pairs and tracks the min/max magnitude across the frame.
- Then pulses the normalizer start, presents max/min, and replays the frame as sign-magnitude pairs on the sspect valid/rdy interface.
- Frame N+1 cannot be accepted until frame N has drained. Single-buffered by design.

Parameters:
- PAIRS, 128, pairs per frame; must be a power of 2, minimum 2.
- AW, 7, pointer width; equals log2(PAIRS).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- frame_start  in  1  synchronous abort/clear pulse; returns the block to FILL.
- raw_data_1  in  16  signed two's-complement sample, first of the pair.
- raw_data_2  in  16  signed two's-complement sample, second of the pair.
- raw_valid  in  1  raw pair valid.
- raw_rdy  out  1  raw pair accepted when raw_valid & raw_rdy.
- max  out  16  largest magnitude in the last completed frame.
- min  out  16  smallest magnitude in the last completed frame.
- norm_start  out  1  one-cycle pulse; max/min are valid from this cycle onward.
- sspect_minus_1  out  1  sign of pair element 1.
- sspect_data_1  out  16  magnitude of pair element 1.
- sspect_minus_2  out  1  sign of pair element 2.
- sspect_data_2  out  16  magnitude of pair element 2.
- sspect_valid  out  1  output pair valid.
- sspect_rdy  in  1  output pair consumed when sspect_valid & sspect_rdy.
- busy  out  1  high in REPORT and DRAIN.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is FILL; wr_ptr and rd_ptr are 0.
  - Internal accumulators: acc_max = 0, acc_min = 16'h7FFF.
- Magnitude: mag = raw[15] ? -raw : raw.
  - -32768 saturates to 32767.
  - minus = raw[15]; a zero sample gives minus = 0.
- States: FILL -> REPORT -> DRAIN -> FILL.
- FILL:
  - raw_rdy = 1, driven from a register, not from raw_valid.
  - On handshake: write {raw_data_1, raw_data_2} to buffer[wr_ptr].
  - Update acc_max/acc_min using the magnitudes of both elements; both elements are compared in the same cycle.
  - Increment wr_ptr.
  - On the handshake at wr_ptr = PAIRS-1, go to REPORT. wr_ptr wraps to 0.
- REPORT (exactly one cycle):
  - norm_start = 1.
  - max <= acc_max and min <= acc_min, registered and visible in the same cycle as norm_start.
  - max/min hold until the next REPORT.
  - Issue the buffer read of address 0; go to DRAIN.
- DRAIN:
  - sspect_valid rises on the cycle after REPORT, carrying pair 0.
  - Data and sign are held stable while sspect_valid & !sspect_rdy.
  - Full throughput: one pair per cycle while sspect_rdy is held high. Requires a prefetch read of rd_ptr+1 on handshake.
  - sspect_valid must not depend combinationally on sspect_rdy.
  - Order is preserved: data_1 comes from raw_data_1 and data_2 from raw_data_2.
  - After the handshake of pair PAIRS-1:
    - sspect_valid drops the next cycle;
    - rd_ptr wraps to 0;
    - acc_max = 0 and acc_min = 16'h7FFF;
    - go to FILL.
- raw_rdy = 0 in REPORT and DRAIN. Raw data offered during those states is held off, never dropped.
- frame_start (any state, highest priority):
  - Next cycle: state = FILL, pointers = 0, accumulators re-initialised, sspect_valid = 0.
  - max/min are unchanged.
  - A raw handshake in the same cycle as frame_start is discarded.
- Reset mid-operation: immediate return to reset values. Buffer contents are don't-care.
- Latency:
  - Last raw handshake at cycle T gives norm_start at T+1 and the first sspect_valid at T+2.
  - A full frame drains in PAIRS cycles when sspect_rdy is held high.

Decomposition:
- Package normalizer_pkg holds:
  - the state encoding (FILL, REPORT, DRAIN);
  - MAG_SAT = 16'h7FFF;
  - MIN_INIT = 16'h7FFF.
- Sub-module normalizer_pair_ram:
  - simple dual-port memory, 32 bits by PAIRS;
  - one write port, one synchronous-read port with 1-cycle read latency;
  - no reset on the array.

Test Plan:
- Basic frame, PAIRS = 4:
  - Stimulus: pairs (5,-3), (-7,2), (0,1), (4,-6) with raw_valid continuous.
  - Required: norm_start one cycle after the 4th handshake, max = 7, min = 0.
  - Output: (0,5,1,3), (1,7,0,2), (0,0,0,1), (0,4,1,6) as (minus_1, data_1, minus_2, data_2), at one pair per cycle.
- Saturation:
  - Stimulus: pair (-32768, 32767).
  - Required: data_1 = 32767 with minus_1 = 1; max = 32767.
- Backpressure:
  - Stimulus: sspect_rdy toggled 1,0,0,1,...
  - Required: each pair is held stable while rdy = 0; no pair is duplicated or skipped; raw_rdy = 0 throughout DRAIN.
- Abort:
  - Stimulus: frame_start after the 2nd pair of a fill.
  - Required: the next 4 pairs form a fresh frame; max/min reflect only those 4 pairs.
  - Stimulus: frame_start mid-DRAIN.
  - Required: sspect_valid = 0 next cycle.
- Async reset:
  - Stimulus: rst low mid-DRAIN, asynchronously between clock edges.
  - Required: outputs are 0 immediately; after release, raw_rdy = 1 in FILL.
- Back-to-back frames:
  - Stimulus: two frames of all-equal magnitude, 9 then 2.
  - Required: the second REPORT gives max = min = 2; the accumulators did not carry over from the first frame.
